// File: rtl/cmp_vector_checker.sv
// Exhaustive self-checking sweep for a WIDTH-bit equality comparator: drives every
// operand pair, samples the returned aeqb after a settle window, and tallies mismatches.
module cmp_vector_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2,
    parameter int ERRW   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             aeqb_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERRW-1:0]  err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
    localparam logic [1:0] AFTER_LOAD = (SETTLE_LD == 4'd0) ? CHECK : WAIT;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] idx;
    logic [3:0]         settle_cnt;
    logic               mismatch;

    // Operands come straight from the index register, so the ports are glitch-free.
    assign a = idx[2*WIDTH-1:WIDTH];
    assign b = idx[WIDTH-1:0];

    assign mismatch = (aeqb_in != (a == b));
    assign busy     = (state == WAIT) || (state == CHECK);
    assign done     = (state == DONE);
    assign pass     = done && (err_count == '0);

    // NOTE: all state below uses non-blocking assignments and the async reset
    // clears every register, so a mid-sweep reset returns the outputs at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx        <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        settle_cnt <= SETTLE_LD;
                        state      <= AFTER_LOAD;
                    end
                end
                WAIT: begin
                    settle_cnt <= settle_cnt - 1'b1;
                    if (settle_cnt <= 4'd1) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_a     <= a;
                            fail_b     <= b;
                        end
                    end
                    if (&idx) begin
                        state <= DONE;
                    end else begin
                        idx        <= idx + 1'b1;
                        settle_cnt <= SETTLE_LD;
                        state      <= AFTER_LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
